spad_read_controller_ifmap: RTL and testbench
=============================================

SPAD_READ_CONTROLLER_IFMAP -- requirements
Module: spad_read_controller_ifmap

Interface
REQ-001 Parameter SPAD_ADDR_WIDTH, default 3: width of every scratchpad address.
REQ-002 Parameter SPAD_DEPTH, default 7: highest scratchpad address; the ring holds SPAD_DEPTH+1 entries.
REQ-003 Parameter LEN_WIDTH, default 3: width of filt_len and stride.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle go pulse, accepted only in IDLE.
REQ-007 done  input  1  end of layer; forces return to IDLE.
REQ-008 stall  input  1  global freeze.
REQ-009 valid_start  input  1  start_data holds the first address of the current row.
REQ-010 valid_end  input  1  end_data holds the last address (inclusive) of the current row.
REQ-011 start_data, end_data  input  SPAD_ADDR_WIDTH  row bounds from the IFMap write controller.
REQ-012 spad_waddr  input  SPAD_ADDR_WIDTH  next address the write side will fill.
REQ-013 filt_len, stride  input  LEN_WIDTH  window length (>=1) and slide step (>=1), sampled on start.
REQ-014 spad_raddr  output  SPAD_ADDR_WIDTH  scratchpad read address.
REQ-015 ren_spad  output  1  scratchpad read enable.
REQ-016 win_first, win_last  output  1  qualify the first and last read of each window.
REQ-017 r_next_IF  output  1  one-cycle request to the write controller for the next row.
REQ-018 row_done  output  1  one-cycle pulse when the last window of a row has been read.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_ROW, READ_WIN and ROW_DONE.
REQ-020 IDLE: start -> latch filt_len and stride, pulse r_next_IF, go to WAIT_ROW.
REQ-021 WAIT_ROW: valid_start -> base<=start_data, k<=0, go to READ_WIN.
REQ-022 READ_WIN: spad_raddr = (base+k) mod (SPAD_DEPTH+1), computed combinationally, including the wrap from SPAD_DEPTH to 0.
REQ-023 avail = valid_end | (spad_raddr != spad_waddr); ren_spad = avail & ~stall in READ_WIN, 0 in every other state.
REQ-024 k SHALL increment only on a cycle with ren_spad=1.
REQ-025 win_first = ren_spad & (k==0); win_last = ren_spad & (k==filt_len-1).
REQ-026 On win_last, rem = (end_data-base) mod (SPAD_DEPTH+1), computed SPAD_ADDR_WIDTH+1 bits wide.
REQ-027 If valid_end=0 or rem >= stride+filt_len-1, then base <= (base+stride) mod (SPAD_DEPTH+1), k<=0, stay in READ_WIN.
REQ-028 Otherwise go to ROW_DONE.
REQ-029 If the first window does not fit (valid_end=1 and rem < filt_len-1 at base=start_data), WAIT_ROW SHALL go directly to ROW_DONE without reading.
REQ-030 ROW_DONE SHALL pulse row_done and r_next_IF together for one cycle, then go to WAIT_ROW.
REQ-031 done SHALL force IDLE from any state on the next edge and take priority over every other transition.
REQ-032 stall SHALL freeze all registers; single-cycle pulses are held off and emitted on the first unstalled cycle.
REQ-033 Simultaneous valid_start and done SHALL resolve to IDLE.

Reset
REQ-034 rst SHALL put the FSM in IDLE and clear base, k, and the latched filt_len/stride to 0.
REQ-035 In the cycle after rst, every output SHALL be 0.
REQ-036 rst mid-row SHALL abort without emitting row_done.

Structure
REQ-037 The state encoding, IDLE..ROW_DONE as 2-bit constants, SHALL live in a shared package reused by the write controller.
REQ-038 One sub-module, mod_ring_add, SHALL implement the (a+b) mod (SPAD_DEPTH+1) adder used for both spad_raddr and the base update.
REQ-039 Base and k SHALL use the existing register and counter primitives with the stall input.

Verification
REQ-040 DEPTH=7, filt 3, stride 1, start 0, end 4, valid_end=1 -> raddr 0,1,2,1,2,3,2,3,4; 9 reads; row_done once.
REQ-041 Wrap case: start 6, end 2, filt 3, stride 2 -> raddr 6,7,0,0,1,2, then row_done.
REQ-042 valid_end=0, spad_waddr=2, base 0, filt 3 -> ren_spad low at raddr 2 until spad_waddr=3, then the read proceeds.
REQ-043 stall held 3 cycles during the second read -> raddr and k frozen, no duplicate or skipped address.
REQ-044 rst asserted during READ_WIN -> outputs 0 next cycle; start then restarts cleanly with r_next_IF.
REQ-045 done during READ_WIN -> IDLE next cycle, no row_done.

Source files
------------

// File: rtl/spad_read_controller_ifmap_pkg.sv
// Shared definitions for the IFMap scratchpad controllers.
// The state encoding is reused by the write controller, so keep values stable.
package spad_read_controller_ifmap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ROW = 2'd1,
    ST_READ_WIN = 2'd2,
    ST_ROW_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/spad_read_controller_ifmap_ring_add.sv
// (a + b) mod (DEPTH+1) for a scratchpad ring that need not be a power of two.
module mod_ring_add #(
  parameter int AW    = 3,
  parameter int BW    = 3,
  parameter int DEPTH = 7
) (
  input  logic [AW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  output logic [AW-1:0] sum_o
);

  localparam int SW   = ((AW > BW) ? AW : BW) + 1;
  localparam int RING = DEPTH + 1;

  logic [SW-1:0] sum_full;
  logic [SW-1:0] sum_mod;

  always_comb begin
    sum_full = SW'(a_i) + SW'(b_i);
    sum_mod  = sum_full % SW'(RING);
    sum_o    = sum_mod[AW-1:0];
  end

endmodule

// File: rtl/spad_read_controller_ifmap.sv
// IFMap scratchpad read controller: walks sliding windows over each row held in
// the ring buffer, throttled against the write pointer until the row end is known.
module spad_read_controller_ifmap
  import spad_read_controller_ifmap_pkg::*;
#(
  parameter int SPAD_ADDR_WIDTH = 3,
  parameter int SPAD_DEPTH      = 7,
  parameter int LEN_WIDTH       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       done_i,
  input  logic                       stall_i,
  input  logic                       valid_start_i,
  input  logic                       valid_end_i,
  input  logic [SPAD_ADDR_WIDTH-1:0] start_data_i,
  input  logic [SPAD_ADDR_WIDTH-1:0] end_data_i,
  input  logic [SPAD_ADDR_WIDTH-1:0] spad_waddr_i,
  input  logic [LEN_WIDTH-1:0]       filt_len_i,
  input  logic [LEN_WIDTH-1:0]       stride_i,
  output logic [SPAD_ADDR_WIDTH-1:0] spad_raddr_o,
  output logic                       ren_spad_o,
  output logic                       win_first_o,
  output logic                       win_last_o,
  output logic                       r_next_IF_o,
  output logic                       row_done_o,
  output rd_state_e                  dbg_state_o
);

  localparam int AW   = SPAD_ADDR_WIDTH;
  localparam int LW   = LEN_WIDTH;
  localparam int CW   = ((AW > LW) ? AW : LW) + 2;
  localparam int RING = SPAD_DEPTH + 1;

  rd_state_e     state_q;
  logic [AW-1:0] base_q;
  logic [LW-1:0] k_q;
  logic [LW-1:0] filt_q;
  logic [LW-1:0] stride_q;
  logic          r_next_q;
  logic          row_done_q;

  logic [AW-1:0] raddr_ring;
  logic [AW-1:0] base_next;
  logic          in_read;
  logic          avail;
  logic          ren;
  logic          last_rd;
  logic [CW-1:0] rem_cur;
  logic [CW-1:0] rem_first;
  logic [CW-1:0] span_first;
  logic [CW-1:0] span_slide;

  // Forward distance from one ring slot to another, always non-negative.
  function automatic logic [CW-1:0] ring_dist(input logic [AW-1:0] to_a,
                                              input logic [AW-1:0] from_a);
    if (to_a >= from_a) return CW'(to_a) - CW'(from_a);
    else                return CW'(to_a) + CW'(RING) - CW'(from_a);
  endfunction

  mod_ring_add #(.AW(AW), .BW(LW), .DEPTH(SPAD_DEPTH)) u_raddr_add (
    .a_i  (base_q),
    .b_i  (k_q),
    .sum_o(raddr_ring)
  );

  mod_ring_add #(.AW(AW), .BW(LW), .DEPTH(SPAD_DEPTH)) u_base_add (
    .a_i  (base_q),
    .b_i  (stride_q),
    .sum_o(base_next)
  );

  always_comb begin
    in_read    = (state_q == ST_READ_WIN);
    avail      = valid_end_i | (raddr_ring != spad_waddr_i);
    ren        = in_read & avail & ~stall_i;
    last_rd    = ren & (k_q == (filt_q - LW'(1)));
    rem_cur    = ring_dist(end_data_i, base_q);
    rem_first  = ring_dist(end_data_i, start_data_i);
    span_first = CW'(filt_q) - CW'(1);
    span_slide = CW'(stride_q) + CW'(filt_q) - CW'(1);
  end

  assign spad_raddr_o = in_read ? raddr_ring : '0;
  assign ren_spad_o   = ren;
  assign win_first_o  = ren & (k_q == '0);
  assign win_last_o   = last_rd;
  // Pulses stay parked in their registers while stalled and surface once released.
  assign r_next_IF_o  = r_next_q & ~stall_i;
  assign row_done_o   = row_done_q & ~stall_i;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      k_q        <= '0;
      filt_q     <= '0;
      stride_q   <= '0;
      r_next_q   <= 1'b0;
      row_done_q <= 1'b0;
    end else if (done_i) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      r_next_q   <= 1'b0;
      row_done_q <= 1'b0;
    end else if (!stall_i) begin
      r_next_q   <= 1'b0;
      row_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            filt_q   <= filt_len_i;
            stride_q <= stride_i;
            r_next_q <= 1'b1;
            state_q  <= ST_WAIT_ROW;
          end
        end
        ST_WAIT_ROW: begin
          if (valid_start_i) begin
            if (valid_end_i && (rem_first < span_first)) begin
              r_next_q   <= 1'b1;
              row_done_q <= 1'b1;
              state_q    <= ST_ROW_DONE;
            end else begin
              base_q  <= start_data_i;
              k_q     <= '0;
              state_q <= ST_READ_WIN;
            end
          end
        end
        ST_READ_WIN: begin
          if (last_rd) begin
            if (!valid_end_i || (rem_cur >= span_slide)) begin
              base_q <= base_next;
              k_q    <= '0;
            end else begin
              r_next_q   <= 1'b1;
              row_done_q <= 1'b1;
              state_q    <= ST_ROW_DONE;
            end
          end else if (ren) begin
            k_q <= k_q + LW'(1);
          end
        end
        ST_ROW_DONE: state_q <= ST_WAIT_ROW;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spad_read_controller_ifmap.sv
// Bench for spad_read_controller_ifmap: scoreboard of expected reads derived from
// window arithmetic, directed corner cases plus randomized rows with random stalls.
module tb_spad_read_controller_ifmap;
  import spad_read_controller_ifmap_pkg::*;

  localparam int AW   = 3;
  localparam int LW   = 3;
  localparam int RING = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          done;
  logic          stall;
  logic          valid_start;
  logic          valid_end;
  logic [AW-1:0] start_data;
  logic [AW-1:0] end_data;
  logic [AW-1:0] spad_waddr;
  logic [LW-1:0] filt_len;
  logic [LW-1:0] stride;
  logic [AW-1:0] spad_raddr;
  logic          ren_spad;
  logic          win_first;
  logic          win_last;
  logic          r_next_IF;
  logic          row_done;
  rd_state_e     dbg_state;

  int total, bad;
  int reads_seen, rd_seen, rd_exp, rn_seen, rn_exp;
  int cur_filt, cur_stride;
  logic [AW+1:0] exp_q[$];

  spad_read_controller_ifmap #(
    .SPAD_ADDR_WIDTH(AW), .SPAD_DEPTH(RING - 1), .LEN_WIDTH(LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .done_i       (done),
    .stall_i      (stall),
    .valid_start_i(valid_start),
    .valid_end_i  (valid_end),
    .start_data_i (start_data),
    .end_data_i   (end_data),
    .spad_waddr_i (spad_waddr),
    .filt_len_i   (filt_len),
    .stride_i     (stride),
    .spad_raddr_o (spad_raddr),
    .ren_spad_o   (ren_spad),
    .win_first_o  (win_first),
    .win_last_o   (win_last),
    .r_next_IF_o  (r_next_IF),
    .row_done_o   (row_done),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every read
  always @(negedge clk) begin
    if (!rst) begin
      if (ren_spad) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got addr %0d, expected no read", spad_raddr);
        end else begin
          check("read_addr_first_last", {spad_raddr, win_first, win_last}, exp_q.pop_front());
        end
        reads_seen++;
      end else begin
        check("qual_without_read", {win_first, win_last}, 2'b00);
      end
      if (row_done) begin
        rd_seen++;
        check("row_done_with_rnext", r_next_IF, 1'b1);
      end
      if (r_next_IF) rn_seen++;
    end
  end

  // reference model: windows start at offsets w*stride from the row start and
  // fit while w*stride + filt - 1 does not exceed the row span
  task automatic push_row(input int s, input int e);
    int span, nwin;
    span = (e - s + RING) % RING;
    nwin = (span >= cur_filt - 1) ? (span - (cur_filt - 1)) / cur_stride + 1 : 0;
    for (int w = 0; w < nwin; w++)
      for (int j = 0; j < cur_filt; j++)
        exp_q.push_back({AW'((s + w * cur_stride + j) % RING), j == 0, j == cur_filt - 1});
    rd_exp++;
    rn_exp++;
  endtask

  // driver tasks
  task automatic start_cmd(input int f, input int s);
    start = 1'b1; filt_len = LW'(f); stride = LW'(s);
    @(posedge clk); #1;
    start = 1'b0;
    cur_filt = f; cur_stride = s;
    rn_exp++;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic wait_reads(input int tgt);
    for (int i = 0; i < 100 && reads_seen < tgt; i++) @(posedge clk);
    check("wait_reads_timeout", reads_seen >= tgt, 1'b1);
  endtask

  task automatic wait_row_end(input bit rand_stall);
    for (int i = 0; i < 400 && rd_seen != rd_exp; i++) begin
      @(posedge clk); #1;
      stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    stall = 1'b0;
    valid_start = 1'b0;
    check("row_done_count", rd_seen, rd_exp);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic run_row(input int s, input int e, input bit rand_stall);
    push_row(s, e);
    start_data = AW'(s); end_data = AW'(e); valid_end = 1'b1; valid_start = 1'b1;
    wait_row_end(rand_stall);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_raddr"}, spad_raddr, 0);
    check({tag, "_ren"}, ren_spad, 0);
    check({tag, "_first_last"}, {win_first, win_last}, 0);
    check({tag, "_rnext"}, r_next_IF, 0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int b;
    total = 0; bad = 0;
    reads_seen = 0; rd_seen = 0; rd_exp = 0; rn_seen = 0; rn_exp = 0;
    cur_filt = 1; cur_stride = 1;
    rst = 1'b1; start = 0; done = 0; stall = 0; valid_start = 0; valid_end = 0;
    start_data = '0; end_data = '0; spad_waddr = '0; filt_len = '0; stride = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // 0..4, filt 3 stride 1: nine reads
    start_cmd(3, 1);
    run_row(0, 4, 1'b0);

    // wrap through the top of the ring
    pulse_done();
    start_cmd(3, 2);
    run_row(6, 2, 1'b0);

    // stall held over the second read
    pulse_done();
    start_cmd(3, 1);
    push_row(0, 4);
    start_data = 0; end_data = 4; valid_end = 1'b1; valid_start = 1'b1;
    wait_reads(reads_seen + 1);
    #1 stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_raddr_held", spad_raddr, 1);
      check("stall_no_ren", ren_spad, 0);
      @(posedge clk);
    end
    #1 stall = 1'b0;
    wait_row_end(1'b0);

    // reads throttled by the write pointer until the row end is known
    push_row(0, 3);
    start_data = 0; end_data = 3; valid_end = 1'b0; spad_waddr = 2; valid_start = 1'b1;
    b = reads_seen;
    wait_reads(b + 2);
    repeat (3) begin
      @(negedge clk);
      check("throttle_raddr2", spad_raddr, 2);
      check("throttle_ren_low2", ren_spad, 0);
    end
    @(posedge clk); #1 spad_waddr = 3;
    wait_reads(b + 5);
    @(negedge clk);
    check("throttle_raddr3", spad_raddr, 3);
    check("throttle_ren_low3", ren_spad, 0);
    @(posedge clk); #1 valid_end = 1'b1;
    wait_row_end(1'b0);
    spad_waddr = 0;

    // reset mid-row
    push_row(0, 4);
    start_data = 0; end_data = 4; valid_start = 1'b1;
    wait_reads(reads_seen + 2);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; valid_start = 1'b0;
    @(negedge clk);
    check_all_zero("mid_row_reset");
    exp_q.delete(); rd_exp--; rn_exp--;
    check("reset_no_row_done", rd_seen, rd_exp);
    start_cmd(3, 1);
    @(negedge clk);
    check("restart_rnext", r_next_IF, 1'b1);
    run_row(0, 4, 1'b0);

    // done mid-row
    push_row(1, 6);
    start_data = 1; end_data = 6; valid_start = 1'b1;
    wait_reads(reads_seen + 2);
    #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0; valid_start = 1'b0;
    @(negedge clk);
    check("done_state_idle", dbg_state, ST_IDLE);
    check("done_ren_low", ren_spad, 0);
    check("done_no_row_done", row_done, 0);
    exp_q.delete(); rd_exp--; rn_exp--;
    check("done_row_done_count", rd_seen, rd_exp);

    // valid_start together with done
    start_cmd(3, 1);
    start_data = 0; end_data = 4; valid_start = 1'b1; done = 1'b1;
    @(posedge clk); #1 done = 1'b0; valid_start = 1'b0;
    @(negedge clk);
    check("vs_done_state_idle", dbg_state, ST_IDLE);
    check("vs_done_ren_low", ren_spad, 0);

    // randomized rows with random stalls
    for (int bt = 0; bt < 5; bt++) begin
      pulse_done();
      start_cmd($urandom_range(1, 4), $urandom_range(1, 3));
      for (int r = 0; r < 5; r++)
        run_row($urandom_range(0, RING - 1), $urandom_range(0, RING - 1), 1'b1);
    end

    repeat (3) @(posedge clk);
    check("rnext_count", rn_seen, rn_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
